duty_cycle_meter: RTL and testbench

DUTY_CYCLE_METER -- requirements
Module: duty_cycle_meter

---
 rtl/duty_cycle_pkg.sv | 16 +
 rtl/duty_cycle_channel.sv | 78 +++++++
 rtl/duty_cycle_meter.sv | 108 ++++++++++
 tb/tb_duty_cycle_meter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/duty_cycle_pkg.sv
// duty_cycle_pkg
//   Shared constants and FSM encoding for the duty-cycle meter.
//   DEF_NUM_CH / DEF_CNT_W / DEF_SYNC_STAGES : default parameter values.
//   state_e : window sequencer states (IDLE, RUN).
package duty_cycle_pkg;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_CNT_W       = 17;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/duty_cycle_channel.sv
// duty_cycle_channel
//   One measured channel: synchronizer, high-time counter, capture register
//   and stuck flags.
//   clk, reset     : clock, asynchronous active-low reset
//   ring_in        : asynchronous input bit under measurement
//   run            : window in progress (counter accumulates)
//   capture        : terminal cycle of the window (load value and flags)
//   win_eff        : effective window length of the current window
//   value          : high-cycle count of the last completed window
//   stuck_hi/lo    : last window was high/low on every cycle
module duty_cycle_channel
  import duty_cycle_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES  // legal 2..4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ring_in,
  input  logic             run,
  input  logic             capture,
  input  logic [CNT_W-1:0] win_eff,
  output logic [CNT_W-1:0] value,
  output logic             stuck_hi,
  output logic             stuck_lo
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       value_q, value_d;
  logic                   stuck_hi_q, stuck_hi_d;
  logic                   stuck_lo_q, stuck_lo_d;
  logic                   hi;
  logic [CNT_W-1:0]       cnt_inc;

  assign hi      = sync_q[SYNC_STAGES-1];
  // Count including the current sample, so the terminal cycle is counted.
  assign cnt_inc = cnt_q + CNT_W'(hi);

  always_comb begin
    // Synchronizer shifts every cycle regardless of enable.
    sync_d     = {sync_q[SYNC_STAGES-2:0], ring_in};
    cnt_d      = '0;
    value_d    = value_q;
    stuck_hi_d = stuck_hi_q;
    stuck_lo_d = stuck_lo_q;
    // Counter clears on capture so the next window starts back-to-back.
    if (run && !capture) begin
      cnt_d = cnt_inc;
    end
    if (capture) begin
      value_d    = cnt_inc;
      stuck_hi_d = (cnt_inc == win_eff);
      stuck_lo_d = (cnt_inc == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      value_q    <= '0;
      stuck_hi_q <= 1'b0;
      stuck_lo_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      value_q    <= value_d;
      stuck_hi_q <= stuck_hi_d;
      stuck_lo_q <= stuck_lo_d;
    end
  end

  assign value    = value_q;
  assign stuck_hi = stuck_hi_q;
  assign stuck_lo = stuck_lo_q;

endmodule

// File: rtl/duty_cycle_meter.sv
// duty_cycle_meter
//   Measures the high time of NUM_CH asynchronous inputs over repeating
//   windows of win_len clk cycles (minimum 2).
//   clk, reset : clock, asynchronous active-low reset
//   enable     : run windows back-to-back; low aborts and idles
//   win_len    : window length, sampled at each window start
//   ring_in    : asynchronous inputs, one bit per channel
//   value      : per-channel last capture, channel k at [k*CNT_W +: CNT_W]
//   valid      : one-cycle pulse when value/stuck_hi/stuck_lo were updated
//   stuck_hi/lo: per channel, last window was high/low every cycle
//   busy       : window in progress
//   dbg_state  : current sequencer state
// Handshake: valid is a push-only strobe with no ready; value and the stuck
// flags are stable from the valid cycle until the next valid.
module duty_cycle_meter
  import duty_cycle_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [CNT_W-1:0]        win_len,
  input  logic [NUM_CH-1:0]       ring_in,
  output logic [NUM_CH*CNT_W-1:0] value,
  output logic                    valid,
  output logic [NUM_CH-1:0]       stuck_hi,
  output logic [NUM_CH-1:0]       stuck_lo,
  output logic                    busy,
  output state_e                  dbg_state
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] win_eff_q, win_eff_d;
  logic             valid_q, valid_d;
  logic             terminal;
  logic             start;
  logic             run;

  assign run      = (state_q == ST_RUN);
  assign terminal = run && (win_cnt_q == win_eff_q - CNT_W'(1));

  // enable alone decides the next state: a terminal cycle with enable high
  // simply rolls into the next window.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable)  state_d = ST_RUN;
      ST_RUN:  if (!enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A window starts when leaving IDLE or when rolling over from a terminal cycle.
  assign start = (state_d == ST_RUN) && (!run || terminal);

  always_comb begin
    win_eff_d = win_eff_q;
    win_cnt_d = '0;
    if (start) begin
      win_eff_d = (win_len < CNT_W'(2)) ? CNT_W'(2) : win_len;
    end
    if (run && !terminal && enable) begin
      win_cnt_d = win_cnt_q + CNT_W'(1);
    end
    // Capture happens on the terminal cycle even if enable just fell.
    valid_d = terminal;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      win_cnt_q <= '0;
      win_eff_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      win_eff_q <= win_eff_d;
      valid_q   <= valid_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    duty_cycle_channel #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .ring_in  (ring_in[k]),
      .run      (run),
      .capture  (terminal),
      .win_eff  (win_eff_q),
      .value    (value[k*CNT_W +: CNT_W]),
      .stuck_hi (stuck_hi[k]),
      .stuck_lo (stuck_lo[k])
    );
  end

  assign valid     = valid_q;
  assign busy      = run;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_duty_cycle_meter.sv
module tb_duty_cycle_meter;
  import duty_cycle_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 17;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset;
  logic                    enable;
  logic [CNT_W-1:0]        win_len;
  logic [NUM_CH-1:0]       ring_hi;
  logic                    pat0_en;
  logic                    pat0;
  wire  [NUM_CH-1:0]       ring_in;
  logic [NUM_CH*CNT_W-1:0] value;
  logic                    valid;
  logic [NUM_CH-1:0]       stuck_hi;
  logic [NUM_CH-1:0]       stuck_lo;
  logic                    busy;
  state_e                  dbg_state;

  assign ring_in = {ring_hi[NUM_CH-1:1], pat0_en ? pat0 : ring_hi[0]};

  duty_cycle_meter #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .win_len   (win_len),
    .ring_in   (ring_in),
    .value     (value),
    .valid     (valid),
    .stuck_hi  (stuck_hi),
    .stuck_lo  (stuck_lo),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ch0 pattern: period 100, 25 high / 75 low; any 100-cycle window holds 25 highs.
  int pat_ph = 0;
  initial begin
    pat0 = 1'b0;
    forever begin
      @(posedge clk); #1;
      pat_ph = (pat_ph == 99) ? 0 : pat_ph + 1;
      pat0   = (pat_ph < 25);
    end
  end

  // ---------------- scoreboard ----------------
  int chk_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ch_val(input int k);
    return 32'(value[k*CNT_W +: CNT_W]);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Ticks until valid is seen; n = ticks taken. Expiry is a failed check.
  task automatic wait_valid(input string tag, input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      n++;
      if (valid) return;
    end
    check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  int n;
  int seen;

  initial begin
    reset   = 1'b0;
    enable  = 1'b0;
    win_len = 17'd100;
    ring_hi = '0;
    pat0_en = 1'b0;

    // reset state
    tick(3);
    check("rst_value", 32'(value[31:0]) | 32'(value[NUM_CH*CNT_W-1:32]), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_stuck_hi", 32'(stuck_hi), 32'd0);
    check("rst_stuck_lo", 32'(stuck_lo), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    reset = 1'b1;
    // 25% duty on ch0, window 100
    pat0_en = 1'b1;
    tick(10);
    check("idle_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    tick();
    check("start_busy", 32'(busy), 32'd1);
    wait_valid("a_first", 250, n);
    check("a_first_ch0", ch_val(0), 32'd25);
    for (int w = 0; w < 3; w++) exp_q.push_back(32'd25);
    while (exp_q.size() > 0) begin
      wait_valid("a_win", 150, n);
      check("a_interval", 32'(n), 32'd100);
      check("a_ch0", ch_val(0), exp_q.pop_front());
    end
    tick();
    check("a_valid_pulse", 32'(valid), 32'd0);
    check("a_ch1", ch_val(1), 32'd0);
    check("a_stuck_lo", 32'(stuck_lo), 32'b1110);
    check("a_stuck_hi", 32'(stuck_hi), 32'd0);

    // stuck channels, window 50
    enable = 1'b0;
    tick();
    check("b_idle_busy", 32'(busy), 32'd0);
    pat0_en = 1'b0;
    ring_hi = 4'b0010;
    win_len = 17'd50;
    tick(5);
    enable = 1'b1;
    wait_valid("b_first", 100, n);
    check("b_ch1", ch_val(1), 32'd50);
    check("b_ch2", ch_val(2), 32'd0);
    check("b_stuck_hi", 32'(stuck_hi), 32'b0010);
    check("b_stuck_lo", 32'(stuck_lo), 32'b1101);
    wait_valid("b_second", 100, n);
    check("b_interval", 32'(n), 32'd50);

    // short windows: win_len 1 and 0 act as 2
    win_len = 17'd1;
    wait_valid("c_w50", 100, n);
    check("c_w50_interval", 32'(n), 32'd50);
    wait_valid("c_len1", 100, n);
    check("c_len1_interval", 32'(n), 32'd2);
    check("c_len1_ch1", ch_val(1), 32'd2);
    check("c_len1_stuck_hi", 32'(stuck_hi), 32'b0010);
    win_len = 17'd0;
    wait_valid("c_len1b", 100, n);
    check("c_len1b_interval", 32'(n), 32'd2);
    wait_valid("c_len0", 100, n);
    check("c_len0_interval", 32'(n), 32'd2);
    check("c_len0_ch1", ch_val(1), 32'd2);

    // win_len changed mid-window
    win_len = 17'd100;
    wait_valid("d_w2", 100, n);
    check("d_w2_interval", 32'(n), 32'd2);
    tick(30);
    win_len = 17'd10;
    wait_valid("d_w100", 150, n);
    check("d_w100_interval", 32'(30 + n), 32'd100);
    check("d_w100_ch1", ch_val(1), 32'd100);
    wait_valid("d_w10", 150, n);
    check("d_w10_interval", 32'(n), 32'd10);
    check("d_w10_ch1", ch_val(1), 32'd10);

    // enable dropped at win_cnt = 40
    win_len = 17'd100;
    wait_valid("e_w10", 50, n);
    check("e_w10_interval", 32'(n), 32'd10);
    tick(40);
    check("e_busy_before", 32'(busy), 32'd1);
    check("e_state_run", 32'(dbg_state), 32'(ST_RUN));
    enable = 1'b0;
    tick();
    check("e_busy_after", 32'(busy), 32'd0);
    check("e_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    seen = 32'(valid);
    for (int i = 0; i < 5; i++) begin
      tick();
      seen += 32'(valid);
    end
    check("e_no_valid", 32'(seen), 32'd0);
    check("e_hold_ch1", ch_val(1), 32'd10);
    enable = 1'b1;
    wait_valid("e_reenable", 200, n);
    check("e_reenable_interval", 32'(n), 32'd101);
    check("e_reenable_ch1", ch_val(1), 32'd100);
    check("e_reenable_stuck_hi", 32'(stuck_hi), 32'b0010);

    // enable falls on the terminal cycle: capture still happens
    tick(99);
    enable = 1'b0;
    tick();
    check("f_term_valid", 32'(valid), 32'd1);
    check("f_term_busy", 32'(busy), 32'd0);
    check("f_term_ch1", ch_val(1), 32'd100);
    tick();
    check("f_term_valid_end", 32'(valid), 32'd0);

    // reset mid-window
    enable = 1'b1;
    tick(21);
    check("g_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("g_value", 32'(value[31:0]) | 32'(value[NUM_CH*CNT_W-1:32]), 32'd0);
    check("g_stuck_hi", 32'(stuck_hi), 32'd0);
    check("g_stuck_lo", 32'(stuck_lo), 32'd0);
    check("g_busy", 32'(busy), 32'd0);
    check("g_valid", 32'(valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen += 32'(valid);
    end
    check("g_no_valid", 32'(seen), 32'd0);
    enable = 1'b0;
    reset  = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
